// File: rtl/add_arbiter_if.sv
// Purpose: bundles the two requester channels and the shared adder result of add_arbiter.
// Latency: none, wiring only.
// Backpressure: none; requesters hold req until they see their gnt pulse.
interface add_arbiter_if;
    logic       req0;
    logic [3:0] a0;
    logic [3:0] b0;
    logic       req1;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       gnt0;
    logic       gnt1;
    logic       busy;
    logic       done;
    logic       done_id;
    logic [4:0] sum;

    // requester side: drives requests and operands, observes grants and results
    modport master (
        output req0, a0, b0, req1, a1, b1,
        input  gnt0, gnt1, busy, done, done_id, sum
    );

    // arbiter side
    modport slave (
        input  req0, a0, b0, req1, a1, b1,
        output gnt0, gnt1, busy, done, done_id, sum
    );
endinterface

// File: rtl/add_arbiter.sv
// Purpose: round-robin arbiter sharing one 4-bit adder between two requesters.
// Latency: done pulses LAT cycles after the grant cycle; next grant no earlier than LAT+1.
// Backpressure: requests are only sampled in IDLE; a requester keeps req high until granted.
module add_arbiter #(
    parameter int LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    add_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // CALC occupies LAT-1 cycles; the counter is loaded with that count at grant
    localparam logic [1:0] CNT_LOAD = 2'(LAT - 1);

    state_t     state;
    logic [1:0] cnt;
    logic       last;       // requester served most recently; 1 after reset so req0 wins the first tie
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic       owner;
    logic       busy_q;
    logic       done_q;
    logic       done_id_q;
    logic [4:0] sum_q;

    logic       any_req;
    logic       pick1;
    logic       grant;
    logic [3:0] sel_a;
    logic [3:0] sel_b;

    // Arbitration: a lone request always wins; on a tie the requester not served last wins.
    // Grants are a decode of IDLE and the live requests so operands are captured on the same edge.
    always_comb begin
        any_req = bus.req0 | bus.req1;
        pick1   = bus.req1 & (~bus.req0 | ~last);
        grant   = (state == IDLE) & any_req & ~rst;
        sel_a   = pick1 ? bus.a1 : bus.a0;
        sel_b   = pick1 ? bus.b1 : bus.b0;
    end

    assign bus.gnt0    = grant & ~pick1;
    assign bus.gnt1    = grant & pick1;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign bus.sum     = sum_q;

    // Control FSM with registered busy/done/sum; reset discards any in-flight addition.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            last      <= 1'b1;
            op_a      <= 4'h0;
            op_b      <= 4'h0;
            owner     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            sum_q     <= 5'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        last   <= pick1;
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        owner  <= pick1;
                        busy_q <= 1'b1;
                        if (LAT == 1) begin
                            // no CALC phase: result is ready in the very next cycle
                            state     <= DONE;
                            done_q    <= 1'b1;
                            sum_q     <= {1'b0, sel_a} + {1'b0, sel_b};
                            done_id_q <= pick1;
                        end else begin
                            state <= CALC;
                            cnt   <= CNT_LOAD;
                        end
                    end
                end
                CALC: begin
                    if (cnt == 2'd1) begin
                        state     <= DONE;
                        cnt       <= 2'd0;
                        done_q    <= 1'b1;
                        sum_q     <= {1'b0, op_a} + {1'b0, op_b};
                        done_id_q <= owner;
                    end else begin
                        cnt <= cnt - 2'd1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    cnt    <= 2'd0;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_arbiter.sv
// Purpose: self-checking bench for add_arbiter at LAT=2 and LAT=1 side by side.
// Latency: observes gnt in the request cycle and done LAT cycles later.
// Backpressure: bench holds or drops requests per scenario; no stalls on the result side.
module tb_add_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    add_arbiter_if bus2 ();
    add_arbiter_if bus1 ();

    add_arbiter #(.LAT(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    add_arbiter #(.LAT(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // observed tuple {gnt0, gnt1, busy, done, done_id, sum}
    function automatic logic [9:0] obs2();
        return {bus2.gnt0, bus2.gnt1, bus2.busy, bus2.done, bus2.done_id, bus2.sum};
    endfunction

    function automatic logic [9:0] obs1();
        return {bus1.gnt0, bus1.gnt1, bus1.busy, bus1.done, bus1.done_id, bus1.sum};
    endfunction

    task automatic set2(input logic r0, input logic [3:0] x0, input logic [3:0] y0,
                        input logic r1, input logic [3:0] x1, input logic [3:0] y1);
        bus2.req0 = r0; bus2.a0 = x0; bus2.b0 = y0;
        bus2.req1 = r1; bus2.a1 = x1; bus2.b1 = y1;
    endtask

    task automatic set1(input logic r0, input logic [3:0] x0, input logic [3:0] y0,
                        input logic r1, input logic [3:0] x1, input logic [3:0] y1);
        bus1.req0 = r0; bus1.a0 = x0; bus1.b0 = y0;
        bus1.req1 = r1; bus1.a1 = x1; bus1.b1 = y1;
    endtask

    // leaves the bench just after the negedge where rst dropped
    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        set2(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        set1(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        set2(1'b1, 4'h5, 4'h5, 1'b1, 4'h5, 4'h5);
        set1(1'b1, 4'h5, 4'h5, 1'b1, 4'h5, 4'h5);
        #1;
        checks++;
        if (obs2() !== 10'h000) begin
            errors++; $display("FAIL reset_lat2: got %b exp %b", obs2(), 10'h000);
        end
        checks++;
        if (obs1() !== 10'h000) begin
            errors++; $display("FAIL reset_lat1: got %b exp %b", obs1(), 10'h000);
        end
        @(negedge clk);
        rst = 1'b0;
        set2(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        set1(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        #1;
        checks++;
        if (obs2() !== 10'h000) begin
            errors++; $display("FAIL reset_release_lat2: got %b exp %b", obs2(), 10'h000);
        end
        checks++;
        if (obs1() !== 10'h000) begin
            errors++; $display("FAIL reset_release_lat1: got %b exp %b", obs1(), 10'h000);
        end
    endtask

    task automatic test_single();
        logic [9:0] ex [4];
        ex = '{{4'b1000, 1'b0, 5'h00}, {4'b0010, 1'b0, 5'h00},
               {4'b0011, 1'b0, 5'h0d}, {4'b0000, 1'b0, 5'h0d}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set2(i == 0, 4'ha, 4'h3, 1'b0, 4'h0, 4'h0);
            #1;
            checks++;
            if (obs2() !== ex[i]) begin
                errors++; $display("FAIL single step%0d: got %b exp %b", i, obs2(), ex[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [4:0] hs;
        logic       hid;
        logic [9:0] ex;
        int         g;
        hs  = 5'h00;
        hid = 1'b0;
        pulse_reset();
        // grant possible on the very first edge after reset release
        for (int k = 0; k < 13; k++) begin
            if (k > 0) @(negedge clk);
            if (k < 12) set2(1'b1, 4'h1, 4'h1, 1'b1, 4'he, 4'h1);
            else        set2(1'b0, 4'h1, 4'h1, 1'b0, 4'he, 4'h1);
            #1;
            g = (k / 3) % 2;
            if (k == 12) begin
                ex = {4'b0000, hid, hs};
            end else if (k % 3 == 0) begin
                ex = {g == 0, g == 1, 2'b00, hid, hs};
            end else if (k % 3 == 1) begin
                ex = {4'b0010, hid, hs};
            end else begin
                hs  = (g == 0) ? 5'h02 : 5'h0f;
                hid = (g == 1);
                ex  = {4'b0011, hid, hs};
            end
            checks++;
            if (obs2() !== ex) begin
                errors++; $display("FAIL round_robin k=%0d: got %b exp %b", k, obs2(), ex);
            end
        end
    endtask

    task automatic test_max_sum();
        logic [9:0] ex [4];
        ex = '{{4'b0100, 1'b1, 5'h0f}, {4'b0010, 1'b1, 5'h0f},
               {4'b0011, 1'b1, 5'h1e}, {4'b0000, 1'b1, 5'h1e}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set2(1'b0, 4'h0, 4'h0, i == 0, 4'hf, 4'hf);
            #1;
            checks++;
            if (obs2() !== ex[i]) begin
                errors++; $display("FAIL max_sum step%0d: got %b exp %b", i, obs2(), ex[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [9:0] ex [9];
        ex = '{{4'b1000, 1'b1, 5'h1e}, 10'h000, 10'h000, 10'h000, 10'h000,
               {4'b1000, 1'b0, 5'h00}, {4'b0010, 1'b0, 5'h00},
               {4'b0011, 1'b0, 5'h04}, {4'b0000, 1'b0, 5'h04}};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            rst = (i == 1);
            if (i == 0)      set2(1'b1, 4'h3, 4'h4, 1'b0, 4'h0, 4'h0);
            else if (i == 5) set2(1'b1, 4'h2, 4'h2, 1'b1, 4'h9, 4'h9);
            else             set2(1'b0, 4'h2, 4'h2, 1'b0, 4'h9, 4'h9);
            #1;
            checks++;
            if (obs2() !== ex[i]) begin
                errors++; $display("FAIL reset_mid step%0d: got %b exp %b", i, obs2(), ex[i]);
            end
        end
    endtask

    task automatic test_lat1();
        logic [9:0] ex [5];
        ex = '{{4'b1000, 1'b0, 5'h00}, {4'b0011, 1'b0, 5'h0a}, {4'b1000, 1'b0, 5'h0a},
               {4'b0011, 1'b0, 5'h02}, {4'b0000, 1'b0, 5'h02}};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) set1(1'b1, 4'h2, 4'h8, 1'b0, 4'h0, 4'h0);
            else        set1(i < 3, 4'h1, 4'h1, 1'b0, 4'h0, 4'h0);
            #1;
            checks++;
            if (obs1() !== ex[i]) begin
                errors++; $display("FAIL lat1 step%0d: got %b exp %b", i, obs1(), ex[i]);
            end
        end
    endtask

    task automatic test_operand_change();
        logic [9:0] ex [4];
        ex = '{{4'b1000, 1'b0, 5'h04}, {4'b0010, 1'b0, 5'h04},
               {4'b0011, 1'b0, 5'h08}, {4'b0000, 1'b0, 5'h08}};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0)      set2(1'b1, 4'h7, 4'h1, 1'b0, 4'h0, 4'h0);
            else if (i == 1) set2(1'b0, 4'hf, 4'hf, 1'b0, 4'hc, 4'hc);
            else             set2(1'b0, 4'h0, 4'h0, 1'b0, 4'h3, 4'h3);
            #1;
            checks++;
            if (obs2() !== ex[i]) begin
                errors++; $display("FAIL operand_change step%0d: got %b exp %b", i, obs2(), ex[i]);
            end
        end
    endtask

    // Random traffic to both latencies; the model tracks when the adder is free,
    // who was served last, and when each result is due, all in cycle arithmetic.
    task automatic test_random();
        int         free_at [2];
        int         g_at [2];
        int         done_at [2];
        logic       last [2];
        logic [4:0] pend_sum [2];
        logic       pend_id [2];
        logic [4:0] hold_sum [2];
        logic       hold_id [2];
        logic       r0, r1, win, eg, edone, ebusy;
        logic [3:0] x0, y0, x1, y1;
        logic [9:0] got, ex;
        int         lat;
        for (int d = 0; d < 2; d++) begin
            free_at[d] = 0; g_at[d] = -100; done_at[d] = -1; last[d] = 1'b1;
            pend_sum[d] = 5'h00; pend_id[d] = 1'b0; hold_sum[d] = 5'h00; hold_id[d] = 1'b0;
        end
        pulse_reset();
        for (int t = 0; t < 500; t++) begin
            if (t > 0) @(negedge clk);
            r0 = ($urandom_range(0, 2) != 0);
            r1 = ($urandom_range(0, 2) != 0);
            x0 = 4'($urandom_range(0, 15)); y0 = 4'($urandom_range(0, 15));
            x1 = 4'($urandom_range(0, 15)); y1 = 4'($urandom_range(0, 15));
            set2(r0, x0, y0, r1, x1, y1);
            set1(r0, x0, y0, r1, x1, y1);
            #1;
            for (int d = 0; d < 2; d++) begin
                lat = (d == 0) ? 2 : 1;
                got = (d == 0) ? obs2() : obs1();
                eg  = (t >= free_at[d]) && (r0 || r1);
                win = (r0 && r1) ? !last[d] : r1;
                edone = (t == done_at[d]);
                if (edone) begin
                    hold_sum[d] = pend_sum[d];
                    hold_id[d]  = pend_id[d];
                end
                ebusy = (t > g_at[d]) && (t <= g_at[d] + lat);
                ex = {eg && !win, eg && win, ebusy, edone, hold_id[d], hold_sum[d]};
                checks++;
                if (got !== ex) begin
                    errors++;
                    $display("FAIL random lat%0d t=%0d: got %b exp %b", lat, t, got, ex);
                end
                if (eg) begin
                    last[d]     = win;
                    g_at[d]     = t;
                    done_at[d]  = t + lat;
                    free_at[d]  = t + lat + 1;
                    pend_id[d]  = win;
                    pend_sum[d] = win ? ({1'b0, x1} + {1'b0, y1}) : ({1'b0, x0} + {1'b0, y0});
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        set2(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        set1(1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0);
        test_reset();
        test_single();
        test_round_robin();
        test_max_sum();
        test_reset_mid();
        test_lat1();
        test_operand_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 SHALL have parameter LAT, default 2, meaning cycles from grant to result; legal range 1..4.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port req0  input  1  requester 0 asks for one addition.
REQ-005 SHALL have port a0  input  4  requester 0 operand a.
REQ-006 SHALL have port b0  input  4  requester 0 operand b.
REQ-007 SHALL have port req1  input  1  requester 1 asks for one addition.
REQ-008 SHALL have port a1  input  4  requester 1 operand a.
REQ-009 SHALL have port b1  input  4  requester 1 operand b.
REQ-010 SHALL have port gnt0  output  1  one-cycle pulse: requester 0 operands captured.
REQ-011 SHALL have port gnt1  output  1  one-cycle pulse: requester 1 operands captured.
REQ-012 SHALL have port busy  output  1  adder occupied (states CALC, DONE).
REQ-013 SHALL have port done  output  1  one-cycle pulse: sum valid.
REQ-014 SHALL have port done_id  output  1  requester that owns the current sum.
REQ-015 SHALL have port sum  output  5  registered result a+b.

Function
REQ-016 SHALL implement FSM states IDLE, CALC, DONE; reset state IDLE.
REQ-017 SHALL sample req0/req1 only in IDLE; requests in CALC or DONE are ignored until the next IDLE cycle.
REQ-018 In IDLE with at least one request, SHALL assert exactly one of gnt0/gnt1 for one cycle, capture that requester's a,b on the same edge, and enter CALC.
REQ-019 Single request SHALL be granted regardless of priority.
REQ-020 Simultaneous requests SHALL be resolved round-robin: the requester not served last wins; the last-served pointer resets to 1, so req0 wins the first tie.
REQ-021 If grant occurs in cycle N, done SHALL pulse in cycle N+LAT with sum and done_id valid in that cycle.
REQ-022 CALC SHALL last LAT-1 cycles via a down-counter; with LAT=1, CALC SHALL be skipped and the FSM SHALL go directly to DONE.
REQ-023 DONE SHALL last one cycle and then return to IDLE; the earliest next grant SHALL be cycle N+LAT+1.
REQ-024 sum SHALL equal zero-extended a + b in 5 bits (max 5'h1e) with no overflow, and SHALL hold its value between done pulses.
REQ-025 busy SHALL be 1 from cycle N+1 through cycle N+LAT, and 0 otherwise.
REQ-026 Operand changes after capture SHALL NOT affect the in-flight result.
REQ-027 gnt0 and gnt1 SHALL never be 1 together; done and any gnt SHALL never be 1 together.

Reset
REQ-028 rst=1 SHALL immediately force gnt0, gnt1, busy, done, done_id to 0, sum to 5'h00, FSM to IDLE, counter to 0, and last-served pointer to 1.
REQ-029 Reset during CALC or DONE SHALL discard the in-flight operation; no done for it SHALL ever appear.
REQ-030 The first grant after rst deasserts SHALL be possible on the first rising edge with rst=0.

Verification
REQ-031 LAT=2, single req0 with a0=4'ha, b0=4'h3 -> gnt0 at N; done=1, sum=5'h0d, done_id=0 at N+2; busy=1 at N+1..N+2.
REQ-032 After reset, req0 and req1 held together, a0=1, b0=1, a1=4'he, b1=4'h1 -> grants alternate gnt0, gnt1, gnt0, ... with sums 5'h02, 5'h0f and grants spaced LAT+1 cycles apart.
REQ-033 req1 with a1=4'hf, b1=4'hf -> sum=5'h1e, done_id=1.
REQ-034 rst pulsed at N+1 after a grant -> all outputs 0 at once; no done follows; next req0 is granted and treated as post-reset tie-break (req0 first).
REQ-035 LAT=1: req0 a0=2, b0=8 -> done at N+1 with sum=5'h0a; next grant at N+2.
REQ-036 Operands changed at N+1 after a0=4'h7, b0=4'h1 grant -> sum=5'h08 regardless.
